grid_move_ctrl: RTL and testbench

Parametrised sprite movement controller for the 96x64 OLED game screen. Converts held direction buttons into a sprite position, updated once per movement tick. Checks each candidate step against a runtime-loadable table of rectangular walls, one wall per clock. Sits between the debounced button inputs and the sprite renderer; replaces fixed-gap collision with a generic wall list and adds clamping, blocked flags and overrun detection.

---
 rtl/move_pkg.sv | 19 +
 rtl/rect_overlap.sv | 21 ++
 rtl/grid_move_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_grid_move_ctrl.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/move_pkg.sv
// rtl/move_pkg.sv - scan state encoding, wall field layout and overlap test for grid_move_ctrl
package move_pkg;

   typedef enum logic [2:0] {IDLE, SCAN_X, COMMIT_X, SCAN_Y, COMMIT_Y} move_state_t;

   // Field positions inside one wall entry, each scaled by COORD_W.
   localparam int WALL_X0 = 0;
   localparam int WALL_Y0 = 1;
   localparam int WALL_X1 = 2;
   localparam int WALL_Y1 = 3;

   // Inverted bounds on either axis mark an unused table entry.
   function automatic logic rects_overlap(input int left, input int right, input int top, input int bot,
                                          input int x0, input int y0, input int x1, input int y1);
      if (x0 > x1 || y0 > y1) return 1'b0;
      return !(right < x0 || left > x1 || bot < y0 || top > y1);
   endfunction

endpackage

// File: rtl/rect_overlap.sv
// rtl/rect_overlap.sv - combinational test of a candidate sprite box against one wall entry
module rect_overlap
   import move_pkg::*;
#(
   parameter int COORD_W = 7
) (
   input  logic [COORD_W-1:0]   cand_left,
   input  logic [COORD_W-1:0]   cand_right,
   input  logic [COORD_W-1:0]   cand_top,
   input  logic [COORD_W-1:0]   cand_bot,
   input  logic [4*COORD_W-1:0] wall,
   output logic                 hit
);

   assign hit = rects_overlap(int'(cand_left), int'(cand_right), int'(cand_top), int'(cand_bot),
                              int'(wall[WALL_X0*COORD_W +: COORD_W]),
                              int'(wall[WALL_Y0*COORD_W +: COORD_W]),
                              int'(wall[WALL_X1*COORD_W +: COORD_W]),
                              int'(wall[WALL_Y1*COORD_W +: COORD_W]));

endmodule

// File: rtl/grid_move_ctrl.sv
// rtl/grid_move_ctrl.sv - tick-driven sprite mover with wall scan; MOVE_ACCEL_EN enables step acceleration
module grid_move_ctrl
   import move_pkg::*;
#(
   parameter int SCREEN_W    = 96,
   parameter int SCREEN_H    = 64,
   parameter int SPRITE_W    = 6,
   parameter int SPRITE_H    = 10,
   parameter int COORD_W     = 7,
   parameter int NUM_WALLS   = 4,
   parameter int TICK_DIV    = 1666666,
   parameter int START_X     = 1,
   parameter int START_Y     = 0,
   parameter int MAX_STEP    = 4,
   parameter int ACCEL_TICKS = 8
) (
   input  logic                           basys_clk,
   input  logic                           reset,
   input  logic                           btnU,
   input  logic                           btnD,
   input  logic                           btnL,
   input  logic                           btnR,
   input  logic [NUM_WALLS*4*COORD_W-1:0] wall_rects,
   output logic [COORD_W-1:0]             pos_x,
   output logic [COORD_W-1:0]             pos_y,
   output logic [COORD_W-1:0]             box_left,
   output logic [COORD_W-1:0]             box_right,
   output logic [COORD_W-1:0]             box_top,
   output logic [COORD_W-1:0]             box_bot,
   output logic                           busy,
   output logic                           blocked_x,
   output logic                           blocked_y,
   output logic                           tick_missed
);

   localparam int MAX_X  = SCREEN_W - SPRITE_W;
   localparam int MAX_Y  = SCREEN_H - SPRITE_H;
   localparam int TICK_W = $clog2(TICK_DIV);
   localparam int IDX_W  = 6;

   typedef logic signed [COORD_W:0] delta_t;

   if (TICK_DIV <= 2*NUM_WALLS + 3) begin : g_bad_tick_div
      $error("grid_move_ctrl: TICK_DIV must exceed 2*NUM_WALLS+3");
   end
   if (NUM_WALLS < 1 || NUM_WALLS > 32) begin : g_bad_num_walls
      $error("grid_move_ctrl: NUM_WALLS must be within 1..32");
   end
   if (MAX_STEP < 1 || ACCEL_TICKS < 1) begin : g_bad_accel
      $error("grid_move_ctrl: MAX_STEP and ACCEL_TICKS must be positive");
   end

   move_state_t        state, state_next;
   logic [TICK_W-1:0]  tick_cnt;
   logic               tick_wrap, tick;
   logic [IDX_W-1:0]   wall_idx;
   logic               last_wall, hit_acc, wall_hit, scan_en, scan_y;
   logic [3:0]         dir_new;
   delta_t             step_eff, dx, dy, dx_new, dy_new;
   logic [COORD_W-1:0] cand_x, cand_y, test_left, test_top;

   // tick is a separate net from the wrap so the divider keeps its cadence regardless of tick.
   assign tick_wrap = (tick_cnt == TICK_W'(TICK_DIV - 1));
   assign tick      = tick_wrap;

   always_ff @(posedge basys_clk) begin
      if (reset || tick_wrap) tick_cnt <= '0;
      else                    tick_cnt <= tick_cnt + 1'b1;
   end

   // One-hot-per-axis direction request: {right, left, down, up}; opposing pairs cancel.
   assign dir_new = {btnR & ~btnL, btnL & ~btnR, btnD & ~btnU, btnU & ~btnD};

`ifdef MOVE_ACCEL_EN
   delta_t     step;
   logic [3:0] prev_dir;
   logic [15:0] run_cnt;
   logic       same_dir;

   assign same_dir = (dir_new != 4'b0) && (dir_new == prev_dir);
   assign step_eff = same_dir ? step : delta_t'(1);

   always_ff @(posedge basys_clk) begin
      if (reset) begin
         step     <= delta_t'(1);
         prev_dir <= '0;
         run_cnt  <= '0;
      end else if (state == IDLE && tick) begin
         step     <= step_eff;
         prev_dir <= dir_new;
         run_cnt  <= (dir_new == 4'b0) ? 16'd0 : (same_dir ? run_cnt + 16'd1 : 16'd1);
      end else if (state == COMMIT_Y) begin
         // A block on either axis restarts the run so the next tick moves by one.
         if (blocked_x || hit_acc) begin
            step     <= delta_t'(1);
            prev_dir <= '0;
            run_cnt  <= '0;
         end else if (run_cnt == 16'(ACCEL_TICKS)) begin
            step    <= (int'(step) * 2 >= MAX_STEP) ? delta_t'(MAX_STEP) : step <<< 1;
            run_cnt <= '0;
         end
      end
   end
`else
   assign step_eff = delta_t'(1);
`endif

   always_comb begin
      dx_new = '0;
      dy_new = '0;
      if (dir_new[3])      dx_new = step_eff;
      else if (dir_new[2]) dx_new = -step_eff;
      if (dir_new[1])      dy_new = step_eff;
      else if (dir_new[0]) dy_new = -step_eff;
   end

   function automatic logic [COORD_W-1:0] clamp_axis(input logic [COORD_W-1:0] base, input delta_t d,
                                                     input int hi);
      delta_t sum;
      sum = delta_t'({1'b0, base}) + d;
      if (sum < delta_t'(0))  return '0;
      if (sum > delta_t'(hi)) return COORD_W'(hi);
      return sum[COORD_W-1:0];
   endfunction

   assign cand_x = clamp_axis(pos_x, dx, MAX_X);
   assign cand_y = clamp_axis(pos_y, dy, MAX_Y);

   // The y scan runs against the x already committed this tick.
   assign test_left = scan_y ? pos_x  : cand_x;
   assign test_top  = scan_y ? cand_y : pos_y;
   assign last_wall = (wall_idx == IDX_W'(NUM_WALLS - 1));

   rect_overlap #(.COORD_W(COORD_W)) u_overlap (
      .cand_left  (test_left),
      .cand_right (test_left + COORD_W'(SPRITE_W - 1)),
      .cand_top   (test_top),
      .cand_bot   (test_top + COORD_W'(SPRITE_H - 1)),
      .wall       (wall_rects[int'(wall_idx)*4*COORD_W +: 4*COORD_W]),
      .hit        (wall_hit)
   );

   always_ff @(posedge basys_clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:     if (tick) state_next = (dx_new != '0) ? SCAN_X : COMMIT_X;
         SCAN_X:   if (last_wall) state_next = COMMIT_X;
         COMMIT_X: state_next = (dy != '0) ? SCAN_Y : COMMIT_Y;
         SCAN_Y:   if (last_wall) state_next = COMMIT_Y;
         COMMIT_Y: state_next = IDLE;
         default:  state_next = IDLE;
      endcase
   end

   always_comb begin
      busy    = (state != IDLE);
      scan_en = (state == SCAN_X) || (state == SCAN_Y);
      scan_y  = (state == SCAN_Y);
   end

   always_ff @(posedge basys_clk) begin
      if (reset) begin
         pos_x       <= COORD_W'(START_X);
         pos_y       <= COORD_W'(START_Y);
         box_left    <= COORD_W'(START_X);
         box_right   <= COORD_W'(START_X + SPRITE_W - 1);
         box_top     <= COORD_W'(START_Y);
         box_bot     <= COORD_W'(START_Y + SPRITE_H - 1);
         blocked_x   <= 1'b0;
         blocked_y   <= 1'b0;
         tick_missed <= 1'b0;
         dx          <= '0;
         dy          <= '0;
         wall_idx    <= '0;
         hit_acc     <= 1'b0;
      end else begin
         if (tick && state != IDLE) tick_missed <= 1'b1;
         if (scan_en) begin
            hit_acc  <= hit_acc | wall_hit;
            wall_idx <= wall_idx + 1'b1;
         end
         case (state)
            IDLE: if (tick) begin
               dx       <= dx_new;
               dy       <= dy_new;
               wall_idx <= '0;
               hit_acc  <= 1'b0;
            end
            COMMIT_X: begin
               if (!hit_acc) begin
                  pos_x     <= cand_x;
                  box_left  <= cand_x;
                  box_right <= cand_x + COORD_W'(SPRITE_W - 1);
               end
               blocked_x <= hit_acc;
               hit_acc   <= 1'b0;
               wall_idx  <= '0;
            end
            COMMIT_Y: begin
               if (!hit_acc) begin
                  pos_y   <= cand_y;
                  box_top <= cand_y;
                  box_bot <= cand_y + COORD_W'(SPRITE_H - 1);
               end
               blocked_y <= hit_acc;
               hit_acc   <= 1'b0;
               wall_idx  <= '0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_grid_move_ctrl.sv
// tb/tb_grid_move_ctrl.sv - scoreboard bench for grid_move_ctrl
module tb_grid_move_ctrl;
   import move_pkg::*;

   localparam int NW = 4, CW = 7, TD = 40, SW = 6, SH = 10, MAXX = 90, MAXY = 54, ACC = 2, MAXS = 4;

   logic basys_clk = 1'b0;
   logic reset, btnU, btnD, btnL, btnR;
   logic [NW*4*CW-1:0] wall_rects;
   logic [CW-1:0] pos_x, pos_y, box_left, box_right, box_top, box_bot;
   logic busy, blocked_x, blocked_y, tick_missed;

   grid_move_ctrl #(.COORD_W(CW), .NUM_WALLS(NW), .TICK_DIV(TD), .MAX_STEP(MAXS), .ACCEL_TICKS(ACC)) dut (
      .basys_clk(basys_clk), .reset(reset), .btnU(btnU), .btnD(btnD), .btnL(btnL), .btnR(btnR),
      .wall_rects(wall_rects), .pos_x(pos_x), .pos_y(pos_y), .box_left(box_left),
      .box_right(box_right), .box_top(box_top), .box_bot(box_bot), .busy(busy),
      .blocked_x(blocked_x), .blocked_y(blocked_y), .tick_missed(tick_missed)
   );

   always #5 basys_clk = ~basys_clk;

   typedef struct {int x; int y; int bx; int by; int busy_cyc;} exp_t;
   exp_t sb[$];
   int n_chk = 0, n_pass = 0;
   int wx0[NW], wy0[NW], wx1[NW], wy1[NW];
   int m_x, m_y, m_step, m_cnt;
   logic [3:0] m_dir;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   task automatic set_wall(input int i, input int x0, input int y0, input int x1, input int y1);
      wx0[i] = x0; wy0[i] = y0; wx1[i] = x1; wy1[i] = y1;
      wall_rects[i*4*CW + WALL_X0*CW +: CW] = CW'(x0);
      wall_rects[i*4*CW + WALL_Y0*CW +: CW] = CW'(y0);
      wall_rects[i*4*CW + WALL_X1*CW +: CW] = CW'(x1);
      wall_rects[i*4*CW + WALL_Y1*CW +: CW] = CW'(y1);
   endtask

   function automatic bit m_hit(input int l, input int t);
      for (int i = 0; i < NW; i++)
         if (wx0[i] <= wx1[i] && wy0[i] <= wy1[i] && l + SW - 1 >= wx0[i] && l <= wx1[i] &&
             t + SH - 1 >= wy0[i] && t <= wy1[i]) return 1'b1;
      return 1'b0;
   endfunction

   function automatic int clampi(input int v, input int hi);
      return (v < 0) ? 0 : (v > hi) ? hi : v;
   endfunction

   task automatic model_tick(input bit u, input bit d, input bit l, input bit r);
      logic [3:0] dir;
      int dx, dy;
      bit hx, hy;
      exp_t e;
      hx = 1'b0; hy = 1'b0;
      dir = {r & ~l, l & ~r, d & ~u, u & ~d};
`ifdef MOVE_ACCEL_EN
      if (dir == 4'b0 || dir != m_dir) begin m_step = 1; m_cnt = 0; end
      m_dir = dir;
      if (dir != 4'b0) m_cnt++;
`else
      m_step = 1;
`endif
      dx = dir[3] ? m_step : dir[2] ? -m_step : 0;
      dy = dir[1] ? m_step : dir[0] ? -m_step : 0;
      e.busy_cyc = ((dx != 0) ? NW + 1 : 1) + ((dy != 0) ? NW + 1 : 1);
      if (dx != 0) begin
         hx = m_hit(clampi(m_x + dx, MAXX), m_y);
         if (!hx) m_x = clampi(m_x + dx, MAXX);
      end
      if (dy != 0) begin
         hy = m_hit(m_x, clampi(m_y + dy, MAXY));
         if (!hy) m_y = clampi(m_y + dy, MAXY);
      end
`ifdef MOVE_ACCEL_EN
      if (hx || hy) begin m_step = 1; m_cnt = 0; m_dir = 4'b0; end
      else if (m_cnt == ACC) begin m_step = (2 * m_step > MAXS) ? MAXS : 2 * m_step; m_cnt = 0; end
`endif
      e.x = m_x; e.y = m_y; e.bx = hx; e.by = hy;
      sb.push_back(e);
   endtask

   task automatic do_tick(input bit u, input bit d, input bit l, input bit r, input bit inject,
                          input string tag);
      exp_t e;
      int wait_cyc, bcyc;
      wait_cyc = 0; bcyc = 0;
      btnU = u; btnD = d; btnL = l; btnR = r;
      model_tick(u, d, l, r);
      while (!busy && wait_cyc < 3 * TD) begin @(negedge basys_clk); wait_cyc++; end
      check({tag, "_busy_start"}, 32'(busy), 32'd1);
      while (busy && bcyc < 200) begin
         if (inject && bcyc == 1) force dut.tick = 1'b1;
         if (inject && bcyc == 2) release dut.tick;
         @(negedge basys_clk);
         bcyc++;
      end
      if (inject) release dut.tick;
      e = sb.pop_front();
      check({tag, "_busy_cycles"}, 32'(bcyc), 32'(e.busy_cyc));
      check({tag, "_pos_x"}, 32'(pos_x), 32'(e.x));
      check({tag, "_pos_y"}, 32'(pos_y), 32'(e.y));
      check({tag, "_blocked_x"}, 32'(blocked_x), 32'(e.bx));
      check({tag, "_blocked_y"}, 32'(blocked_y), 32'(e.by));
      check({tag, "_box_left"}, 32'(box_left), 32'(e.x));
      check({tag, "_box_right"}, 32'(box_right), 32'(e.x + SW - 1));
      check({tag, "_box_top"}, 32'(box_top), 32'(e.y));
      check({tag, "_box_bot"}, 32'(box_bot), 32'(e.y + SH - 1));
   endtask

   task automatic model_reset();
      m_x = 1; m_y = 0; m_step = 1; m_cnt = 0; m_dir = 4'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_pos_x"}, 32'(pos_x), 32'd1);
      check({tag, "_pos_y"}, 32'(pos_y), 32'd0);
      check({tag, "_box_right"}, 32'(box_right), 32'd6);
      check({tag, "_box_bot"}, 32'(box_bot), 32'd9);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_blocked_x"}, 32'(blocked_x), 32'd0);
      check({tag, "_blocked_y"}, 32'(blocked_y), 32'd0);
      check({tag, "_tick_missed"}, 32'(tick_missed), 32'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, observed hang expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int wcyc;
      btnU = 0; btnD = 0; btnL = 0; btnR = 0; reset = 1'b1;
      wall_rects = '0;
      for (int i = 0; i < NW; i++) set_wall(i, 127, 127, 0, 0);
      repeat (3) @(negedge basys_clk);
      reset = 1'b0;
      model_reset();
      check_reset_state("reset");

      for (int k = 0; k < 8; k++) do_tick(0, 0, 0, 1, 0, "right_free");
`ifdef MOVE_ACCEL_EN
      check("accel_total_x", 32'(pos_x), 32'd23);
`else
      check("step1_total_x", 32'(pos_x), 32'd9);
`endif

      set_wall(0, m_x + SW + 2, 0, m_x + SW + 4, 63);
      for (int k = 0; k < 5; k++) do_tick(0, 0, 0, 1, 0, "right_wall");
      check("wall_stop_x", 32'(pos_x), 32'(wx0[0] - SW));
      check("wall_stop_blocked", 32'(blocked_x), 32'd1);

      set_wall(0, 127, 127, 0, 0);
      for (int k = 0; k < 27; k++) do_tick(0, 0, 1, 0, 0, "left_clamp");
      check("left_clamp_x", 32'(pos_x), 32'd0);
      check("left_clamp_not_blocked", 32'(blocked_x), 32'd0);

      for (int k = 0; k < 56; k++) do_tick(0, 1, 0, 0, 0, "down_clamp");
      check("down_clamp_y", 32'(pos_y), 32'd54);

      for (int k = 0; k < 2; k++) do_tick(1, 1, 0, 1, 0, "ud_cancel");
      check("ud_cancel_y", 32'(pos_y), 32'd54);
      check("ud_cancel_blocked_y", 32'(blocked_y), 32'd0);

      set_wall(1, 0, 45, 95, 52);
      for (int k = 0; k < 3; k++) do_tick(1, 0, 0, 1, 0, "diag_wall");
      check("diag_blocked_y", 32'(blocked_y), 32'd1);
      check("diag_no_miss", 32'(tick_missed), 32'd0);

      do_tick(0, 0, 0, 1, 1, "inject");
      check("tick_missed_set", 32'(tick_missed), 32'd1);
      do_tick(0, 0, 1, 0, 0, "after_inject");
      check("tick_missed_sticky", 32'(tick_missed), 32'd1);

      btnU = 0; btnD = 0; btnL = 0; btnR = 1;
      wcyc = 0;
      while (!busy && wcyc < 3 * TD) begin @(negedge basys_clk); wcyc++; end
      check("midscan_busy", 32'(busy), 32'd1);
      repeat (2) @(negedge basys_clk);
      reset = 1'b1;
      @(negedge basys_clk);
      check_reset_state("midscan_reset");
      reset = 1'b0;
      model_reset();
      set_wall(1, 127, 127, 0, 0);
      do_tick(0, 0, 0, 1, 0, "post_reset");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
